// File: rtl/sample_i2s_pkg.sv
// Shared types and sizes for the sample_i2s_tx serial audio transmitter.
// Left-justified output is selected at build time with SAMPLE_I2S_LJ_EN.
package sample_i2s_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int SLOT_BITS  = 16;
    localparam int FRAME_BITS = 32;
    localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

endpackage

// File: rtl/sample_i2s_tx_bck_divider.sv
// Bit-clock divider: toggles bck_out every BCK_HALF_PERIOD clocks while run is high.
// rise_en/fall_en are high in the cycle before bck_out rises/falls.
module bck_divider #(
    parameter int BCK_HALF_PERIOD = 16
) (
    input  logic clk_in,
    input  logic reset_n_in,
    input  logic run,
    output logic rise_en,
    output logic fall_en,
    output logic bck_out
);

    localparam int CNT_W = $clog2(BCK_HALF_PERIOD);

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap    = run && (cnt == CNT_W'(BCK_HALF_PERIOD - 1));
    assign rise_en = wrap && !bck_out;
    assign fall_en = wrap && bck_out;

    // Held at zero while stopped so the first rise lands a full half-period after start.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            cnt     <= '0;
            bck_out <= 1'b0;
        end else if (!run) begin
            cnt     <= '0;
            bck_out <= 1'b0;
        end else if (wrap) begin
            cnt     <= '0;
            bck_out <= ~bck_out;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sample_i2s_tx.sv
// Stereo I2S transmitter for the 16-bit mono mixer stream (sample duplicated to L and R).
// Define SAMPLE_I2S_LJ_EN for left-justified framing instead of standard I2S.
module sample_i2s_tx
    import sample_i2s_pkg::*;
#(
    parameter int BCK_HALF_PERIOD = 16
) (
    input  logic                 clk_in,
    input  logic                 reset_n_in,
    input  logic [SLOT_BITS-1:0] data_in,
    input  logic                 data_valid_in,
    output logic                 bck_out,
    output logic                 lrck_out,
    output logic                 sd_out,
    output logic                 underrun_out,
    output logic                 overrun_out
);

    state_t                 state;
    logic [SLOT_BITS-1:0]   hold_q;
    logic                   hold_full;
    logic [SLOT_BITS-1:0]   frame_q;
    logic [SLOT_BITS-1:0]   shift_q;
    logic [BIT_CNT_W-1:0]   bit_cnt;

    logic                   run;
    logic                   bck_rise;
    logic                   bck_fall;
    logic                   boundary;
    logic                   transfer;
    logic [SLOT_BITS-1:0]   next_frame;

    assign run        = (state == RUN);
    assign boundary   = bck_fall && (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1));
    assign transfer   = boundary && hold_full;
    assign next_frame = transfer ? hold_q : frame_q;
    assign lrck_out   = bit_cnt[BIT_CNT_W-1];

    bck_divider #(
        .BCK_HALF_PERIOD(BCK_HALF_PERIOD)
    ) u_bck_divider (
        .clk_in    (clk_in),
        .reset_n_in(reset_n_in),
        .run       (run),
        .rise_en   (bck_rise),
        .fall_en   (bck_fall),
        .bck_out   (bck_out)
    );

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state        <= IDLE;
            hold_q       <= '0;
            hold_full    <= 1'b0;
            frame_q      <= '0;
            shift_q      <= '0;
            bit_cnt      <= '0;
            sd_out       <= 1'b0;
            underrun_out <= 1'b0;
            overrun_out  <= 1'b0;
        end else begin
            underrun_out <= 1'b0;
            overrun_out  <= 1'b0;
            case (state)
                IDLE: begin
                    // The first sample goes straight into the frame; entry counts as a frame boundary.
                    if (data_valid_in) begin
                        state     <= RUN;
                        frame_q   <= data_in;
                        hold_full <= 1'b0;
                        bit_cnt   <= '0;
`ifdef SAMPLE_I2S_LJ_EN
                        sd_out    <= data_in[SLOT_BITS-1];
`else
                        sd_out    <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    // A write in the transfer cycle refills the register the transfer just emptied.
                    if (data_valid_in) begin
                        hold_q    <= data_in;
                        hold_full <= 1'b1;
                        if (hold_full && !transfer) begin
                            overrun_out <= 1'b1;
                        end
                    end else if (transfer) begin
                        hold_full <= 1'b0;
                    end

                    if (boundary) begin
                        frame_q      <= next_frame;
                        underrun_out <= !hold_full;
                    end

                    if (bck_fall) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        shift_q <= shift_q << 1;
`ifdef SAMPLE_I2S_LJ_EN
                        sd_out  <= (bit_cnt[3:0] == 4'hF) ? next_frame[SLOT_BITS-1]
                                                          : shift_q[SLOT_BITS-1];
`else
                        sd_out  <= shift_q[SLOT_BITS-1];
`endif
                    end

                    // Reload mid-way through p=0, after the boundary has settled frame_q.
                    if (bck_rise && (bit_cnt[3:0] == 4'h0)) begin
`ifdef SAMPLE_I2S_LJ_EN
                        shift_q <= frame_q << 1;
`else
                        shift_q <= frame_q;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sample_i2s_tx.sv
// Directed bench for sample_i2s_tx: a receiver rebuilds slot words on BCK rising edges
// and compares them against a queue of expected words filled as stimulus is driven.
module tb_sample_i2s_tx;

    localparam int H = 16;

`ifdef SAMPLE_I2S_LJ_EN
    localparam bit LJ = 1'b1;
`else
    localparam bit LJ = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        dv    = 1'b0;
    logic [15:0] din   = 16'h0;
    logic        bck, lrck, sd, underrun, overrun;

    sample_i2s_tx #(
        .BCK_HALF_PERIOD(H)
    ) dut (
        .clk_in       (clk),
        .reset_n_in   (rst_n),
        .data_in      (din),
        .data_valid_in(dv),
        .bck_out      (bck),
        .lrck_out     (lrck),
        .sd_out       (sd),
        .underrun_out (underrun),
        .overrun_out  (overrun)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard
    logic [15:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_cmp(input logic [15:0] w);
        check("queue_has_entry", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("slot_word", w, exp_q.pop_front());
    endtask

    task automatic push2(input logic [15:0] v);
        exp_q.push_back(v);
        exp_q.push_back(v);
    endtask

    // monitor state
    bit          idle_watch = 1'b0;
    int          idle_bad = 0;
    int          underrun_cnt = 0;
    int          overrun_cnt = 0;
    bit          mon_armed = 1'b0;
    int          entry_cyc = 0;
    int          rise_cnt = 0;
    int          last_rise = 0;
    int          q, p;
    bit          first_slot = 1'b1;
    logic [15:0] word = 16'h0;
    logic        prev_bck = 1'b0, prev_sd = 1'b0, prev_lrck = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_bck  = 1'b0;
            prev_sd   = 1'b0;
            prev_lrck = 1'b0;
        end else begin
            if (idle_watch && (bck || lrck || sd || underrun || overrun)) idle_bad++;
            if (underrun) underrun_cnt++;
            if (overrun)  overrun_cnt++;
            if (mon_armed) begin
                if (sd !== prev_sd || lrck !== prev_lrck)
                    check("change_at_fall", 32'((prev_bck && !bck) || (cyc == entry_cyc)), 1);
                if (!prev_bck && bck) begin
                    if (rise_cnt == 0) check("first_rise", cyc - entry_cyc, H);
                    else               check("bck_period", cyc - last_rise, 2 * H);
                    last_rise = cyc;
                    q = rise_cnt % 32;
                    p = q % 16;
                    check("lrck", lrck, 32'(q / 16));
                    if (LJ) begin
                        word[15 - p] = sd;
                        if (p == 15) pop_cmp(word);
                    end else if (p == 0) begin
                        if (first_slot) check("first_p0_zero", sd, 0);
                        else begin
                            word[0] = sd;
                            pop_cmp(word);
                        end
                        first_slot = 1'b0;
                    end else begin
                        word[16 - p] = sd;
                    end
                    rise_cnt++;
                end
            end
            prev_bck  = bck;
            prev_sd   = sd;
            prev_lrck = lrck;
        end
    end

    // driver tasks
    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe_at(input int c, input logic [15:0] v);
        check("strobe_schedule", 32'(cyc < c), 1);
        wait_until(c - 1);
        dv  = 1'b1;
        din = v;
        @(posedge clk);
        #1;
        dv  = 1'b0;
    endtask

    task automatic arm(input int e);
        mon_armed  = 1'b1;
        entry_cyc  = e;
        rise_cnt   = 0;
        first_slot = 1'b1;
    endtask

    int e;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {bck, lrck, sd, underrun, overrun}, 0);
        rst_n = 1'b1;

        idle_watch = 1'b1;
        wait_until(cyc + 5000);
        idle_watch = 1'b0;
        check("idle_quiet", idle_bad, 0);

        // first sample, then periodic writes mid-frame
        e = cyc + 2;
        arm(e);
        push2(16'hA5C3);
        strobe_at(e, 16'hA5C3);
        check("entry_state", {bck, lrck, sd}, {2'b00, LJ});
        for (int j = 0; j < 3; j++) begin
            push2(16'hA5C3);
            strobe_at(e + 512 + 1024 * j, 16'hA5C3);
        end
        wait_until(e + 4000);
        check("no_underrun_periodic", underrun_cnt, 0);
        check("no_overrun_periodic", overrun_cnt, 0);

        // skipped write: last sample repeats
        push2(16'hA5C3);
        wait_until(e + 4200);
        check("underrun_once", underrun_cnt, 1);
        push2(16'h3C5A);
        strobe_at(e + 4608, 16'h3C5A);

        // overrun
        push2(16'h2222);
        strobe_at(e + 5632, 16'h1111);
        strobe_at(e + 5642, 16'h2222);
        wait_until(e + 5700);
        check("overrun_once", overrun_cnt, 1);

        // write coincident with the frame boundary
        push2(16'h4444);
        strobe_at(e + 6656, 16'h4444);
        push2(16'h5555);
        strobe_at(e + 7168, 16'h5555);
        wait_until(e + 7300);
        check("coincident_no_overrun", overrun_cnt, 1);
        check("coincident_no_underrun", underrun_cnt, 1);
        push2(16'h8001);
        strobe_at(e + 8704, 16'h8001);

        // async reset mid-frame while BCK is high
        wait_until(e + 10550);
        check("pre_reset_bck_high", bck, 1);
        check("words_drained", exp_q.size(), 0);
        check("underrun_after_last", underrun_cnt, 2);
        #2;
        rst_n     = 1'b0;
        mon_armed = 1'b0;
        #1;
        check("async_reset_outputs", {bck, lrck, sd, underrun, overrun}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_bad   = 0;
        idle_watch = 1'b1;
        wait_until(cyc + 2000);
        idle_watch = 1'b0;
        check("post_reset_idle", idle_bad, 0);

        // restart after reset
        e = cyc + 2;
        arm(e);
        push2(16'h6789);
        strobe_at(e, 16'h6789);
        wait_until(e + 1024 + 100);
        check("final_words_drained", exp_q.size(), 0);
        check("final_overrun_total", overrun_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
